// File: rtl/if_id_queue_if.sv
// Handshake bundle between fetch, the IF/ID prefetch queue and decode.
// The queue uses the slave modport; the fetch/decode side uses master.
interface if_id_queue_if #(
    parameter int DEPTH = 4,
    parameter int W     = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          enq_valid;
    logic          enq_ready;
    logic [W-1:0]  enq_ins;
    logic [W-1:0]  enq_pcp4;
    logic          deq_valid;
    logic          deq_ready;
    logic [W-1:0]  deq_ins;
    logic [W-1:0]  deq_pcp4;
    logic          flush;
    logic [CW-1:0] count;
    logic [7:0]    drop_cnt;

    modport slave (
        input  enq_valid, enq_ins, enq_pcp4, deq_ready, flush,
        output enq_ready, deq_valid, deq_ins, deq_pcp4, count, drop_cnt
    );

    modport master (
        output enq_valid, enq_ins, enq_pcp4, deq_ready, flush,
        input  enq_ready, deq_valid, deq_ins, deq_pcp4, count, drop_cnt
    );
endinterface

// File: rtl/if_id_queue.sv
// Instruction prefetch queue: first-word fall-through circular buffer of
// {ins, pcp4} with flush and a saturating count of discarded entries.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          rst,
    if_id_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  ins_mem_r  [DEPTH];
    logic [W-1:0]  pcp4_mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [7:0]    drop_cnt_r;

    logic          enq_ready_s;
    logic          deq_valid_s;
    logic          enq_fire_s;
    logic          deq_fire_s;
    logic [W-1:0]  deq_ins_s;
    logic [W-1:0]  deq_pcp4_s;

    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [CW-1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + 9'(inc);
        if (sum > 9'd255) begin
            sat_add8 = 8'd255;
        end else begin
            sat_add8 = sum[7:0];
        end
    endfunction

    // Handshake decode and fall-through head view (zero when empty).
    always_comb begin
        enq_ready_s = (count_r != CW'(DEPTH));
        deq_valid_s = (count_r != CW'(0));
        enq_fire_s  = bus.enq_valid && enq_ready_s;
        deq_fire_s  = bus.deq_ready && deq_valid_s;
        deq_ins_s   = {W{1'b0}};
        deq_pcp4_s  = {W{1'b0}};
        if (deq_valid_s) begin
            deq_ins_s  = ins_mem_r[rd_ptr_r];
            deq_pcp4_s = pcp4_mem_r[rd_ptr_r];
        end else begin
            deq_ins_s  = {W{1'b0}};
            deq_pcp4_s = {W{1'b0}};
        end
    end

    // Entry storage; contents are meaningless outside the valid window so no reset.
    always_ff @(posedge clk) begin
        if (enq_fire_s && !bus.flush) begin
            ins_mem_r[wr_ptr_r]  <= bus.enq_ins;
            pcp4_mem_r[wr_ptr_r] <= bus.enq_pcp4;
        end
    end

    // Pointers, occupancy and drop counter; flush overrides any handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= PW'(0);
            rd_ptr_r   <= PW'(0);
            count_r    <= CW'(0);
            drop_cnt_r <= 8'd0;
        end else if (bus.flush) begin
            wr_ptr_r   <= PW'(0);
            rd_ptr_r   <= PW'(0);
            count_r    <= CW'(0);
            // count_r < DEPTH whenever an enqueue fires, so the sum fits CW bits
            drop_cnt_r <= sat_add8(drop_cnt_r, count_r + CW'(enq_fire_s));
        end else begin
            if (enq_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (deq_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({enq_fire_s, deq_fire_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign bus.enq_ready = enq_ready_s;
    assign bus.deq_valid = deq_valid_s;
    assign bus.deq_ins   = deq_ins_s;
    assign bus.deq_pcp4  = deq_pcp4_s;
    assign bus.count     = count_r;
    assign bus.drop_cnt  = drop_cnt_r;
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: vector table for fill/drain plus
// hand-written sequences for streaming, flush, saturation and async reset.
module tb_if_id_queue;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   drop_exp;

    if_id_queue_if #(.DEPTH(4), .W(32)) bus ();

    if_id_queue #(.DEPTH(4), .W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ev;
        logic [31:0] ins;
        logic [31:0] pcp4;
        logic        dr;
        logic        fl;
        logic        xdv;
        logic [31:0] xins;
        logic [31:0] xpcp4;
        logic [2:0]  xcnt;
        logic        xer;
        logic [7:0]  xdrop;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic xdv, input logic [31:0] xins,
                           input logic [31:0] xpcp4, input logic [2:0] xcnt,
                           input logic xer, input logic [7:0] xdrop);
        chk($sformatf("%s.deq_valid", tag), 32'(bus.deq_valid), 32'(xdv));
        chk($sformatf("%s.deq_ins", tag),   bus.deq_ins,        xins);
        chk($sformatf("%s.deq_pcp4", tag),  bus.deq_pcp4,       xpcp4);
        chk($sformatf("%s.count", tag),     32'(bus.count),     32'(xcnt));
        chk($sformatf("%s.enq_ready", tag), 32'(bus.enq_ready), 32'(xer));
        chk($sformatf("%s.drop_cnt", tag),  32'(bus.drop_cnt),  32'(xdrop));
    endtask

    task automatic drive(input logic ev, input logic [31:0] ins, input logic [31:0] pcp4,
                         input logic dr, input logic fl);
        bus.enq_valid = ev;
        bus.enq_ins   = ins;
        bus.enq_pcp4  = pcp4;
        bus.deq_ready = dr;
        bus.flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //            ev    ins           pcp4       dr    fl    xdv   xins          xpcp4      cnt   er    drop
        tbl[0] = '{1'b1, 32'h20080005, 32'h84, 1'b0, 1'b0, 1'b1, 32'h20080005, 32'h84, 3'd1, 1'b1, 8'd0};
        tbl[1] = '{1'b1, 32'h00000011, 32'h88, 1'b0, 1'b0, 1'b1, 32'h20080005, 32'h84, 3'd2, 1'b1, 8'd0};
        tbl[2] = '{1'b1, 32'h00000012, 32'h8C, 1'b0, 1'b0, 1'b1, 32'h20080005, 32'h84, 3'd3, 1'b1, 8'd0};
        tbl[3] = '{1'b1, 32'h00000013, 32'h90, 1'b0, 1'b0, 1'b1, 32'h20080005, 32'h84, 3'd4, 1'b0, 8'd0};
        tbl[4] = '{1'b1, 32'h00000014, 32'h94, 1'b0, 1'b0, 1'b1, 32'h20080005, 32'h84, 3'd4, 1'b0, 8'd0};
        tbl[5] = '{1'b1, 32'h00000014, 32'h94, 1'b1, 1'b0, 1'b1, 32'h00000011, 32'h88, 3'd3, 1'b1, 8'd0};
        tbl[6] = '{1'b0, 32'h00000000, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00000012, 32'h8C, 3'd2, 1'b1, 8'd0};
        tbl[7] = '{1'b0, 32'h00000000, 32'h00, 1'b1, 1'b0, 1'b1, 32'h00000013, 32'h90, 3'd1, 1'b1, 8'd0};
        tbl[8] = '{1'b0, 32'h00000000, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00, 3'd0, 1'b1, 8'd0};
        tbl[9] = '{1'b0, 32'h00000000, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00, 3'd0, 1'b1, 8'd0};

        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 8'd0);
        rst = 1'b0;

        // Fill to full, hold a fifth offer, then drain in order
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].ev, tbl[i].ins, tbl[i].pcp4, tbl[i].dr, tbl[i].fl);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].xdv, tbl[i].xins, tbl[i].xpcp4,
                    tbl[i].xcnt, tbl[i].xer, tbl[i].xdrop);
        end

        // Sustained enqueue+dequeue, pointers wrap several times
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h1000 + 32'(k), 32'hA0 + 32'(4 * k), 1'b1, 1'b0);
            step();
            chk_all($sformatf("stream%0d", k), 1'b1, 32'h1000 + 32'(k), 32'hA0 + 32'(4 * k),
                    3'd1, 1'b1, 8'd0);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        chk_all("stream_drain", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 8'd0);

        // Flush with 3 held plus a simultaneous accepted enqueue and dequeue
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h200 + 32'(k), 32'hC0 + 32'(4 * k), 1'b0, 1'b0);
            step();
        end
        chk_all("pre_flush", 1'b1, 32'h200, 32'hC0, 3'd3, 1'b1, 8'd0);
        drive(1'b1, 32'h2FF, 32'hCC, 1'b1, 1'b1);
        step();
        chk_all("flush", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 8'd4);
        drive(1'b1, 32'h300, 32'hD0, 1'b0, 1'b0);
        step();
        chk_all("post_flush_enq", 1'b1, 32'h300, 32'hD0, 3'd1, 1'b1, 8'd4);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();

        // Repeated full-queue flushes drive drop_cnt into saturation
        drop_exp = 4;
        for (int r = 0; r < 66; r++) begin
            for (int j = 0; j < 4; j++) begin
                drive(1'b1, 32'(r * 4 + j), 32'h400 + 32'(4 * j), 1'b0, 1'b0);
                step();
            end
            chk($sformatf("sat%0d.count_full", r), 32'(bus.count), 32'd4);
            chk($sformatf("sat%0d.enq_ready", r), 32'(bus.enq_ready), 32'd0);
            drive(1'b1, 32'hFFFF, 32'h500, 1'b0, 1'b1);
            step();
            drop_exp = (drop_exp + 4 > 255) ? 255 : drop_exp + 4;
            chk($sformatf("sat%0d.drop_cnt", r), 32'(bus.drop_cnt), 32'(drop_exp));
            chk($sformatf("sat%0d.count", r), 32'(bus.count), 32'd0);
        end
        chk("sat_final", 32'(bus.drop_cnt), 32'd255);

        // Build count=2, drop_cnt=7, then async reset between edges
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        chk_all("rst_clear", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 8'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h600 + 32'(k), 32'hF0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        chk("drop3", 32'(bus.drop_cnt), 32'd3);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h700 + 32'(k), 32'hF4, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 32'h7FF, 32'hF8, 1'b0, 1'b1);
        step();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h800 + 32'(k), 32'h104 + 32'(4 * k), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk_all("pre_async", 1'b1, 32'h800, 32'h104, 3'd2, 1'b1, 8'd7);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 8'd0);
        #1 rst = 1'b0;
        drive(1'b1, 32'hABC, 32'hE0, 1'b0, 1'b0);
        step();
        chk_all("after_rst_enq", 1'b1, 32'hABC, 32'hE0, 3'd1, 1'b1, 8'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
